coolgirl_cfg_ctrl: RTL and testbench

//  Configuration controller for the multicart mapping datapath. Decodes CPU writes to $5000-$5007 into shadow

---
 rtl/coolgirl_cfg_pkg.sv | 48 ++++
 rtl/coolgirl_cfg_key_fsm.sv | 48 ++++
 rtl/coolgirl_cfg_ctrl.sv | 117 +++++++++++
 tb/tb_coolgirl_cfg_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coolgirl_cfg_pkg.sv
// Shared definitions for the multicart configuration controller: register indices, bit positions, key FSM states.
// Used by coolgirl_cfg_ctrl and coolgirl_cfg_key_fsm (the latter only when CFG_UNLOCK_KEY_EN is defined).
package coolgirl_cfg_pkg;

  localparam logic [2:0] CFG_R_BASE_LO  = 3'd0;
  localparam logic [2:0] CFG_R_BASE_HI  = 3'd1;
  localparam logic [2:0] CFG_R_CPU_MASK = 3'd2;
  localparam logic [2:0] CFG_R_CHR_MASK = 3'd3;
  localparam logic [2:0] CFG_R_MAPPER   = 3'd4;
  localparam logic [2:0] CFG_R_MISC     = 3'd5;
  localparam logic [2:0] CFG_R_CTRL     = 3'd6;
  localparam logic [2:0] CFG_R_KEY      = 3'd7;

  // R5 layout: {map_rom_on_6000, prg_we, chr_we, sram_page[1:0], sram_en, mirroring[1:0]}
  localparam int R5_MIRR     = 0;
  localparam int R5_SRAM_EN  = 2;
  localparam int R5_SRAM_PG  = 3;
  localparam int R5_CHR_WE   = 5;
  localparam int R5_PRG_WE   = 6;
  localparam int R5_MAP6000  = 7;

  localparam int R6_COMMIT   = 0;
  localparam int R6_LOCK     = 7;

  localparam logic [7:0] DEF_KEY0 = 8'hA5;
  localparam logic [7:0] DEF_KEY1 = 8'h5A;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_K1   = 2'd1,
    KEY_OPEN = 2'd2
  } key_state_t;

  typedef struct packed {
    logic [12:0] base;
    logic [4:0]  cpu_mask;
    logic [4:0]  chr_mask;
    logic [4:0]  mapper;
    logic [2:0]  flags;
    logic [1:0]  mirroring;
    logic        sram_en;
    logic [1:0]  sram_page;
    logic        chr_we;
    logic        prg_we;
    logic        map6000;
  } cfg_regs_t;

endpackage

// File: rtl/coolgirl_cfg_key_fsm.sv
// Two-byte unlock sequence on R7 gating configuration access; OPEN is sticky until reset.
// Latency: cfg_open rises on the negedge that accepts KEY1; no backpressure.
module coolgirl_cfg_key_fsm
  import coolgirl_cfg_pkg::*;
#(
  parameter logic [7:0] KEY0 = DEF_KEY0,
  parameter logic [7:0] KEY1 = DEF_KEY1
) (
  input  logic       m2,
  input  logic       rst,
  input  logic       i_strobe,
  input  logic [2:0] i_idx,
  input  logic [7:0] i_data,
  output logic       o_cfg_open
);

  key_state_t r_state;
  logic       r_open;
  logic       w_key_wr;

  assign w_key_wr   = i_strobe & (i_idx == CFG_R_KEY);
  assign o_cfg_open = r_open;

  always_ff @(negedge m2 or posedge rst) begin
    if (rst) begin
      r_state <= KEY_IDLE;
      r_open  <= 1'b0;
    end else if (i_strobe) begin
      case (r_state)
        KEY_IDLE: begin
          if (w_key_wr && i_data == KEY0) r_state <= KEY_K1;
        end
        KEY_K1: begin
          // A repeated KEY0 keeps the partial match; anything else on the page starts over.
          if (w_key_wr && i_data == KEY1) begin
            r_state <= KEY_OPEN;
            r_open  <= 1'b1;
          end else if (!(w_key_wr && i_data == KEY0)) begin
            r_state <= KEY_IDLE;
          end
        end
        KEY_OPEN: r_state <= KEY_OPEN;
        default:  r_state <= KEY_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/coolgirl_cfg_ctrl.sv
// $5000-$5007 shadow config registers with atomic commit (R6) and sticky lockout; optional CFG_UNLOCK_KEY_EN key gate.
// Latency: live outputs change on the committing negedge of m2; CPU bus has no backpressure, blocked writes are dropped.
module coolgirl_cfg_ctrl
  import coolgirl_cfg_pkg::*;
#(
  parameter logic [2:0] CFG_PAGE = 3'b101,
  parameter logic [7:0] KEY0     = DEF_KEY0,
  parameter logic [7:0] KEY1     = DEF_KEY1
) (
  input  logic        m2,
  input  logic        rst,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [12:0] cpu_base,
  output logic [4:0]  cpu_mask,
  output logic [4:0]  chr_mask,
  output logic [4:0]  mapper,
  output logic [2:0]  flags,
  output logic [1:0]  mirroring,
  output logic        sram_enabled,
  output logic        chr_write_enabled,
  output logic        prg_write_enabled,
  output logic        map_rom_on_6000,
  output logic [1:0]  sram_page,
  output logic        lockout,
  output logic        cfg_pending,
  output logic        cfg_open
);

  cfg_regs_t  r_shadow;
  cfg_regs_t  r_live;
  logic       r_lockout;
  logic       r_pending;
  logic       w_cw;
  logic       w_open;
  logic       w_acc;
  logic [2:0] w_idx;
  logic       w_unused;

  assign w_cw  = romsel & ~cpu_rw_in & (cpu_addr_in[14:12] == CFG_PAGE);
  assign w_idx = cpu_addr_in[2:0];
  assign w_acc = w_cw & w_open & ~r_lockout;

`ifdef CFG_UNLOCK_KEY_EN
  coolgirl_cfg_key_fsm #(
    .KEY0 (KEY0),
    .KEY1 (KEY1)
  ) u_key_fsm (
    .m2         (m2),
    .rst        (rst),
    .i_strobe   (w_cw & ~r_lockout),
    .i_idx      (w_idx),
    .i_data     (cpu_data_in),
    .o_cfg_open (w_open)
  );
  assign w_unused = &{1'b0, cpu_addr_in[11:3]};
`else
  assign w_open   = 1'b1;
  assign w_unused = &{1'b0, cpu_addr_in[11:3], KEY0, KEY1};
`endif

  always_ff @(negedge m2 or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_live    <= '0;
      r_lockout <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_acc) begin
      case (w_idx)
        CFG_R_BASE_LO:  r_shadow.base[7:0]  <= cpu_data_in;
        CFG_R_BASE_HI:  r_shadow.base[12:8] <= cpu_data_in[4:0];
        CFG_R_CPU_MASK: r_shadow.cpu_mask   <= cpu_data_in[4:0];
        CFG_R_CHR_MASK: r_shadow.chr_mask   <= cpu_data_in[4:0];
        CFG_R_MAPPER: begin
          r_shadow.mapper <= cpu_data_in[4:0];
          r_shadow.flags  <= cpu_data_in[7:5];
        end
        CFG_R_MISC: begin
          r_shadow.mirroring <= cpu_data_in[R5_MIRR +: 2];
          r_shadow.sram_en   <= cpu_data_in[R5_SRAM_EN];
          r_shadow.sram_page <= cpu_data_in[R5_SRAM_PG +: 2];
          r_shadow.chr_we    <= cpu_data_in[R5_CHR_WE];
          r_shadow.prg_we    <= cpu_data_in[R5_PRG_WE];
          r_shadow.map6000   <= cpu_data_in[R5_MAP6000];
        end
        CFG_R_CTRL: begin
          // Commit and lock in the same write: the copy still lands, then everything freezes.
          if (cpu_data_in[R6_COMMIT]) begin
            r_live    <= r_shadow;
            r_pending <= 1'b0;
          end
          if (cpu_data_in[R6_LOCK]) r_lockout <= 1'b1;
        end
        default: ;
      endcase
      if (w_idx <= CFG_R_MISC) r_pending <= 1'b1;
    end
  end

  assign cpu_base          = r_live.base;
  assign cpu_mask          = r_live.cpu_mask;
  assign chr_mask          = r_live.chr_mask;
  assign mapper            = r_live.mapper;
  assign flags             = r_live.flags;
  assign mirroring         = r_live.mirroring;
  assign sram_enabled      = r_live.sram_en;
  assign sram_page         = r_live.sram_page;
  assign chr_write_enabled = r_live.chr_we;
  assign prg_write_enabled = r_live.prg_we;
  assign map_rom_on_6000   = r_live.map6000;
  assign lockout           = r_lockout;
  assign cfg_pending       = r_pending;
  assign cfg_open          = w_open;

endmodule

// File: tb/tb_coolgirl_cfg_ctrl.sv
// Self-checking bench for coolgirl_cfg_ctrl; key-sequence scenarios are built when CFG_UNLOCK_KEY_EN is defined.
module tb_coolgirl_cfg_ctrl;

  logic        m2 = 1'b1;
  logic        rst = 1'b1;
  logic        romsel = 1'b0;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic [12:0] cpu_base;
  logic [4:0]  cpu_mask, chr_mask, mapper;
  logic [2:0]  flags;
  logic [1:0]  mirroring, sram_page;
  logic        sram_enabled, chr_write_enabled, prg_write_enabled, map_rom_on_6000;
  logic        lockout, cfg_pending, cfg_open;

  int checks = 0;
  int errors = 0;

  coolgirl_cfg_ctrl dut (
    .m2(m2), .rst(rst), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_base(cpu_base), .cpu_mask(cpu_mask), .chr_mask(chr_mask),
    .mapper(mapper), .flags(flags), .mirroring(mirroring),
    .sram_enabled(sram_enabled), .chr_write_enabled(chr_write_enabled),
    .prg_write_enabled(prg_write_enabled), .map_rom_on_6000(map_rom_on_6000),
    .sram_page(sram_page), .lockout(lockout), .cfg_pending(cfg_pending),
    .cfg_open(cfg_open)
  );

  always #10 m2 = ~m2;

  wire [41:0] w_obs = {cpu_base, cpu_mask, chr_mask, mapper, flags, mirroring,
                       sram_enabled, chr_write_enabled, prg_write_enabled,
                       map_rom_on_6000, sram_page, lockout, cfg_pending, cfg_open};

  // Reference model: raw register bytes as the CPU wrote them, plus key progress (0 idle, 1 half, 2 open).
  logic [7:0] m_sh [6];
  logic [7:0] m_live [6];
  logic       m_lock, m_pend;
  int         m_stage;

  function automatic logic m_open();
`ifdef CFG_UNLOCK_KEY_EN
    return m_stage == 2;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [41:0] exp_vec();
    return {m_live[1][4:0], m_live[0], m_live[2][4:0], m_live[3][4:0],
            m_live[4][4:0], m_live[4][7:5], m_live[5][1:0], m_live[5][2],
            m_live[5][5], m_live[5][6], m_live[5][7], m_live[5][4:3],
            m_lock, m_pend, m_open()};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_sh[i] = 8'h00;
      m_live[i] = 8'h00;
    end
    m_lock = 1'b0;
    m_pend = 1'b0;
    m_stage = 0;
  endfunction

  function automatic void model_step(input logic rs, input logic rw,
                                     input logic [14:0] a, input logic [7:0] d);
    int  idx;
    logic was_open;
    if (!(rs && !rw && a[14:12] == 3'b101) || m_lock) return;
    idx = int'(a[2:0]);
    was_open = m_open();
`ifdef CFG_UNLOCK_KEY_EN
    if (m_stage != 2) begin
      if (idx == 7 && d == 8'hA5) m_stage = 1;
      else if (idx == 7 && d == 8'h5A && m_stage == 1) m_stage = 2;
      else m_stage = 0;
    end
`endif
    if (!was_open) return;
    if (idx < 6) begin
      m_sh[idx] = d;
      m_pend = 1'b1;
    end else if (idx == 6) begin
      if (d[0]) begin
        for (int i = 0; i < 6; i++) m_live[i] = m_sh[i];
        m_pend = 1'b0;
      end
      if (d[7]) m_lock = 1'b1;
    end
  endfunction

  // One CPU cycle: drive after rising M2, model the falling edge, return to an idle read.
  task automatic bus(input logic rs, input logic rw, input logic [14:0] a, input logic [7:0] d);
    @(posedge m2);
    #1;
    romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d;
    @(negedge m2);
    model_step(rs, rw, a, d);
    #1;
    romsel = 1'b0; cpu_rw_in = 1'b1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic do_reset();
    @(posedge m2);
    #2 rst = 1'b1;
    model_reset();
    #4 rst = 1'b0;
    #1;
  endtask

  task automatic unlock();
`ifdef CFG_UNLOCK_KEY_EN
    wr(15'h5007, 8'hA5);
    wr(15'h5007, 8'h5A);
`endif
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge m2);
    #1;
    checks++;
    if (w_obs !== exp_vec()) begin
      errors++; $display("FAIL reset_held: got %h exp %h", w_obs, exp_vec());
    end
    #3 rst = 1'b0;
    @(negedge m2); #1;
    checks++;
    if (w_obs !== exp_vec() || lockout !== 1'b0 || cfg_pending !== 1'b0) begin
      errors++; $display("FAIL reset_release: got %h exp %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_key();
`ifdef CFG_UNLOCK_KEY_EN
    do_reset();
    wr(15'h5000, 8'h55);
    checks++;
    if (w_obs !== exp_vec() || cfg_pending !== 1'b0 || cfg_open !== 1'b0) begin
      errors++; $display("FAIL key_write_before_unlock: got %h exp %h", w_obs, exp_vec());
    end
    wr(15'h5007, 8'hA5); wr(15'h5001, 8'h00); wr(15'h5007, 8'h5A);
    checks++;
    if (cfg_open !== 1'b0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL key_interrupted: got open=%b exp 0", cfg_open);
    end
    wr(15'h5007, 8'hA5); wr(15'h5007, 8'hA5); wr(15'h5007, 8'h5A);
    checks++;
    if (cfg_open !== 1'b1 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL key_repeat_key0: got open=%b exp 1", cfg_open);
    end
    do_reset();
    wr(15'h5007, 8'hA5);
    do_reset();
    wr(15'h5007, 8'h5A);
    checks++;
    if (cfg_open !== 1'b0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL key_reset_midseq: got open=%b exp 0", cfg_open);
    end
`else
    do_reset();
    wr(15'h5007, 8'hA5); wr(15'h5007, 8'h5A); wr(15'h5007, 8'hFF);
    checks++;
    if (cfg_open !== 1'b1 || cfg_pending !== 1'b0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL r7_ignored: got %h exp %h", w_obs, exp_vec());
    end
`endif
  endtask

  task automatic test_commit();
    do_reset(); unlock();
    wr(15'h5000, 8'h12); wr(15'h5002, 8'h1F);
    checks++;
    if (cfg_pending !== 1'b1 || cpu_base !== 13'h000 || cpu_mask !== 5'h00 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL commit_shadow_only: got base=%h mask=%h pend=%b exp 000 00 1", cpu_base, cpu_mask, cfg_pending);
    end
    wr(15'h5006, 8'h01);
    checks++;
    if (cpu_base !== 13'h012 || cpu_mask !== 5'h1F || cfg_pending !== 1'b0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL commit_apply: got base=%h mask=%h pend=%b exp 012 1f 0", cpu_base, cpu_mask, cfg_pending);
    end
  endtask

  task automatic test_lockout();
    do_reset(); unlock();
    wr(15'h5004, 8'hE3); wr(15'h5006, 8'h81);
    checks++;
    if (mapper !== 5'h03 || flags !== 3'h7 || lockout !== 1'b1 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL lock_commit: got map=%h flg=%h lock=%b exp 03 7 1", mapper, flags, lockout);
    end
    wr(15'h5004, 8'h00); wr(15'h5006, 8'h01); wr(15'h5007, 8'hA5);
    checks++;
    if (mapper !== 5'h03 || cfg_pending !== 1'b0 || lockout !== 1'b1 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL lock_frozen: got map=%h pend=%b exp 03 0", mapper, cfg_pending);
    end
  endtask

  task automatic test_ignored();
    do_reset(); unlock();
    wr(15'h5000, 8'h34);
    bus(1'b0, 1'b0, 15'h5000, 8'h77);
    bus(1'b1, 1'b1, 15'h5000, 8'h99);
    bus(1'b1, 1'b0, 15'h4001, 8'h1F);
    checks++;
    if (cfg_pending !== 1'b1 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL ignored_pending: got %h exp %h", w_obs, exp_vec());
    end
    do_reset(); unlock();
    bus(1'b0, 1'b0, 15'h5000, 8'h77);
    bus(1'b1, 1'b1, 15'h5002, 8'h1F);
    checks++;
    if (cfg_pending !== 1'b0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL ignored_no_pending: got pend=%b exp 0", cfg_pending);
    end
    wr(15'h5000, 8'h34);
    bus(1'b0, 1'b0, 15'h5000, 8'h77);
    wr(15'h5006, 8'h01);
    checks++;
    if (cpu_base !== 13'h034 || cpu_mask !== 5'h00 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL ignored_shadow_kept: got base=%h mask=%h exp 034 00", cpu_base, cpu_mask);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); unlock();
    wr(15'h5000, 8'hFF); wr(15'h5001, 8'h1F); wr(15'h5005, 8'hFF); wr(15'h5006, 8'h81);
    checks++;
    if (cpu_base !== 13'h1FFF || lockout !== 1'b1 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL mid_setup: got base=%h lock=%b exp 1fff 1", cpu_base, lockout);
    end
    do_reset();
    checks++;
    if (w_obs[41:1] !== 41'd0 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL mid_reset: got %h exp %h", w_obs, exp_vec());
    end
    unlock();
    wr(15'h5003, 8'h1F);
    do_reset(); unlock();
    wr(15'h5006, 8'h01);
    checks++;
    if (chr_mask !== 5'h00 || w_obs !== exp_vec()) begin
      errors++; $display("FAIL mid_shadow_discard: got chr=%h exp 00", chr_mask);
    end
  endtask

  task automatic test_random();
    logic       rs, rw;
    logic [2:0] page, idx;
    logic [7:0] d;
    do_reset(); unlock();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        if ($urandom_range(0, 1) == 1) unlock();
      end
      rs   = ($urandom_range(0, 9) != 0);
      rw   = ($urandom_range(0, 9) == 0);
      page = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b101;
      idx  = 3'($urandom);
      d    = 8'($urandom);
      if (idx == 3'd6 && $urandom_range(0, 39) != 0) d[7] = 1'b0;
      bus(rs, rw, {page, 9'($urandom), idx}, d);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++; $display("FAIL random_%0d: got %h exp %h", n, w_obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_key();
    test_commit();
    test_lockout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
